// File: rtl/buffet_linebuf_sequencer.sv
// Line-buffer sequencer for a single buffet feeding a ROWS-tall stencil.
// Forwards upstream pushes into the buffet. Walks stencil columns (rows inner,
// columns outer) as read indices relative to the buffet head. Tags returned
// data with its stencil row, and retires consumed rows with shrink requests.
//
// Handshakes: every channel transfers on a cycle where valid and ready are both
// high at the rising edge. A valid never depends on its own ready.
module buffet_linebuf_sequencer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IDX_WIDTH  = 16,
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64,
    parameter int unsigned ROWS       = 3,
    parameter int unsigned MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_valid,
    input  logic                  push_ready,
    output logic [IDX_WIDTH-1:0]  read_idx,
    output logic                  read_valid,
    input  logic                  read_ready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rdata_valid,
    output logic                  rdata_ready,
    output logic [IDX_WIDTH-1:0]  shrink_size,
    output logic                  shrink_valid,
    input  logic                  shrink_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            state_dbg
);

    localparam int unsigned CNT_W = IDX_WIDTH + 8;
    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    localparam logic [CNT_W-1:0]     FRAME_PIX  = CNT_W'(IMG_WIDTH * IMG_HEIGHT);
    localparam logic [CNT_W-1:0]     COL_SPAN   = CNT_W'((ROWS - 1) * IMG_WIDTH + 1);
    localparam logic [IDX_WIDTH-1:0] ROW_STRIDE = IDX_WIDTH'(IMG_WIDTH);
    localparam logic [IDX_WIDTH-1:0] LAST_X     = IDX_WIDTH'(IMG_WIDTH - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_Y     = IDX_WIDTH'(IMG_HEIGHT - ROWS);
    localparam logic [1:0]           LAST_R     = 2'(ROWS - 1);
    localparam logic [IDX_WIDTH-1:0] SZ_ROW     = IDX_WIDTH'(IMG_WIDTH);
    localparam logic [IDX_WIDTH-1:0] SZ_LAST    = IDX_WIDTH'(ROWS * IMG_WIDTH);
    localparam logic [OUT_W-1:0]     OUT_MAX    = OUT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0]     PTR_LAST   = PTR_W'(MAX_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_READ   = 3'd2,
        S_SHRINK = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       pushed_q, pushed_d;
    logic [CNT_W-1:0]       retired_q, retired_d;
    logic [IDX_WIDTH-1:0]   x_q, x_d;
    logic [1:0]             r_q, r_d;
    logic [IDX_WIDTH-1:0]   y_q, y_d;
    logic [OUT_W-1:0]       out_cnt_q, out_cnt_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0]             tag_q [MAX_OUT];
    logic [1:0]             tag_d [MAX_OUT];

    logic                   push_en;
    logic                   push_fire;
    logic                   read_fire;
    logic                   ret_fire;
    logic                   shrink_fire;
    logic [CNT_W-1:0]       occ;
    logic [CNT_W-1:0]       occ_next;
    logic [IDX_WIDTH-1:0]   row_off;
    logic [IDX_WIDTH-1:0]   idx_now;
    logic                   resident;

    // Pass-through paths between upstream, buffet and downstream.
    assign push_data   = in_data;
    assign push_valid  = in_valid & push_en;
    assign in_ready    = push_ready & push_en;
    assign out_data    = rdata;
    assign out_valid   = rdata_valid;
    assign rdata_ready = out_ready;
    assign out_row     = tag_q[rd_ptr_q];
    assign read_idx    = idx_now;
    assign state_dbg   = state_q;

    // Next-state, counters, request generation and tag FIFO bookkeeping.
    always_comb begin
        state_d      = state_q;
        retired_d    = retired_q;
        x_d          = x_q;
        r_d          = r_q;
        y_d          = y_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tag_d        = tag_q;
        done         = 1'b0;
        read_valid   = 1'b0;
        read_fire    = 1'b0;
        shrink_valid = 1'b0;
        shrink_fire  = 1'b0;
        shrink_size  = '0;

        push_en   = (state_q != S_IDLE) && (pushed_q < FRAME_PIX);
        push_fire = in_valid & push_ready & push_en;
        pushed_d  = pushed_q + CNT_W'(push_fire);
        occ       = pushed_q - retired_q;
        // The fill check looks at occupancy including this cycle's push so
        // that reads can start the cycle right after the enabling push.
        occ_next  = pushed_d - retired_q;
        row_off   = IDX_WIDTH'(r_q) * ROW_STRIDE;
        idx_now   = x_q + row_off;
        resident  = occ > {{(CNT_W - IDX_WIDTH){1'b0}}, idx_now};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FILL;
                    pushed_d  = '0;
                    retired_d = '0;
                    x_d       = '0;
                    r_d       = '0;
                    y_d       = '0;
                end
            end
            S_FILL: begin
                if (occ_next >= (CNT_W'(x_q) + COL_SPAN)) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                read_valid = (out_cnt_q < OUT_MAX) && resident;
                read_fire  = read_valid && read_ready;
                if (read_fire) begin
                    if (r_q == LAST_R) begin
                        r_d = '0;
                        if (x_q == LAST_X) begin
                            x_d     = '0;
                            state_d = S_SHRINK;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end
            end
            S_SHRINK: begin
                shrink_valid = (out_cnt_q == '0);
                shrink_size  = (y_q == LAST_Y) ? SZ_LAST : SZ_ROW;
                shrink_fire  = shrink_valid && shrink_ready;
                if (shrink_fire) begin
                    retired_d = retired_q + CNT_W'(shrink_size);
                    x_d       = '0;
                    r_d       = '0;
                    y_d       = y_q + 1'b1;
                    state_d   = (y_q == LAST_Y) ? S_DONE : S_FILL;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Returns only count against reads actually in flight.
        ret_fire  = rdata_valid & out_ready & (out_cnt_q != '0);
        out_cnt_d = out_cnt_q + OUT_W'(read_fire) - OUT_W'(ret_fire);

        if (read_fire) begin
            tag_d[wr_ptr_q] = r_q;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (ret_fire) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    // State register; reset clears every counter and the tag FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pushed_q  <= '0;
            retired_q <= '0;
            x_q       <= '0;
            r_q       <= '0;
            y_q       <= '0;
            out_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tag_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            pushed_q  <= pushed_d;
            retired_q <= retired_d;
            x_q       <= x_d;
            r_q       <= r_d;
            y_q       <= y_d;
            out_cnt_q <= out_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tag_q     <= tag_d;
        end
    end

endmodule
